// File: rtl/serv_trace_pkg.sv
// Shared constants, record layout and frame byte selection for the trace packer.
package serv_trace_pkg;

   localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
   localparam int unsigned FRAME_BYTES  = 14;

   // Record layout: {lost, trap, rd_addr, pc, insn, wdata}
   localparam int unsigned REC_W     = 103;
   localparam int unsigned WDATA_LSB = 0;
   localparam int unsigned INSN_LSB  = 32;
   localparam int unsigned PC_LSB    = 64;
   localparam int unsigned RD_LSB    = 96;
   localparam int unsigned TRAP_BIT  = 101;
   localparam int unsigned LOST_BIT  = 102;

   localparam logic [3:0]  IDX_LAST  = 4'(FRAME_BYTES - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Byte idx of the little-endian frame built from a stored record.
   function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec,
                                             input logic [3:0]       idx,
                                             input logic [7:0]       sync);
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] wd;
      pc   = rec[PC_LSB    +: 32];
      insn = rec[INSN_LSB  +: 32];
      wd   = rec[WDATA_LSB +: 32];
      case (idx)
         4'd0:    frame_byte = sync;
         4'd1:    frame_byte = {rec[LOST_BIT], rec[TRAP_BIT], 1'b0, rec[RD_LSB +: 5]};
         4'd2:    frame_byte = pc[7:0];
         4'd3:    frame_byte = pc[15:8];
         4'd4:    frame_byte = pc[23:16];
         4'd5:    frame_byte = pc[31:24];
         4'd6:    frame_byte = insn[7:0];
         4'd7:    frame_byte = insn[15:8];
         4'd8:    frame_byte = insn[23:16];
         4'd9:    frame_byte = insn[31:24];
         4'd10:   frame_byte = wd[7:0];
         4'd11:   frame_byte = wd[15:8];
         4'd12:   frame_byte = wd[23:16];
         4'd13:   frame_byte = wd[31:24];
         default: frame_byte = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/serv_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Ports: i_push/i_din write, i_pop read, o_dout_c head, o_full_c/o_empty_c/o_count_c status.
module serv_trace_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_din,
   output logic [WIDTH-1:0]         o_dout_c,
   output logic                     o_full_c,
   output logic                     o_empty_c,
   output logic [$clog2(DEPTH):0]   o_count_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic             w_wr_en;
   logic             w_rd_en;

   // Extra pointer bit separates full from empty when the indices match.
   assign o_count_c = r_wr_ptr - r_rd_ptr;
   assign o_full_c  = (o_count_c == PW'(DEPTH));
   assign o_empty_c = (r_wr_ptr == r_rd_ptr);
   assign o_dout_c  = r_mem[r_rd_ptr[AW-1:0]];
   assign w_wr_en   = i_push & ~o_full_c;
   assign w_rd_en   = i_pop & ~o_empty_c;

   // Pointer update
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Storage
   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/serv_trace_packer.sv
// Captures RVFI retirements into a FIFO and serializes them as 14-byte frames.
// Ports: i_rvfi_* retirement inputs, i_en capture enable, o_tdata/o_tvalid/o_tlast/i_tready
// byte stream, o_drop_cnt saturating drop count, o_busy activity flag.
module serv_trace_packer
   import serv_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter logic [7:0]  SYNC  = SYNC_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic        i_rvfi_valid,
   input  logic [31:0] i_rvfi_pc_rdata,
   input  logic [31:0] i_rvfi_insn,
   input  logic [4:0]  i_rvfi_rd_addr,
   input  logic [31:0] i_rvfi_rd_wdata,
   input  logic        i_rvfi_trap,
   output logic [7:0]  o_tdata,
   output logic        o_tvalid,
   input  logic        i_tready,
   output logic        o_tlast,
   output logic [7:0]  o_drop_cnt,
   output logic        o_busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e           r_state;
   logic [3:0]       r_idx;
   logic [REC_W-1:0] r_hold;
   logic             r_lost;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;
   logic             w_last_hs;
   logic             w_send_nxt;
   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_count_nxt;
   logic [31:0]      w_wdata;
   logic [REC_W-1:0] w_din;
   logic [REC_W-1:0] w_head;

   assign w_push    = i_en & i_rvfi_valid & ~w_full;
   assign w_drop    = i_en & i_rvfi_valid & w_full;
   assign w_wdata   = (i_rvfi_rd_addr == 5'd0) ? 32'd0 : i_rvfi_rd_wdata;
   assign w_din     = {r_lost, i_rvfi_trap, i_rvfi_rd_addr,
                       i_rvfi_pc_rdata, i_rvfi_insn, w_wdata};

   // Pop whenever the holding register is (or is about to be) free.
   assign w_last_hs   = (r_state == ST_SEND) & i_tready & (r_idx == IDX_LAST);
   assign w_pop       = ~w_empty & ((r_state == ST_IDLE) | w_last_hs);
   assign w_send_nxt  = w_pop | ((r_state == ST_SEND) & ~w_last_hs);
   assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

   serv_trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_din     (w_din),
      .o_dout_c  (w_head),
      .o_full_c  (w_full),
      .o_empty_c (w_empty),
      .o_count_c (w_count)
   );

   // Serializer: hold register, byte index and registered stream outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= 4'd0;
         r_hold   <= '0;
         o_tvalid <= 1'b0;
         o_tdata  <= 8'h00;
         o_tlast  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_state  <= ST_SEND;
                  r_hold   <= w_head;
                  r_idx    <= 4'd0;
                  o_tvalid <= 1'b1;
                  o_tdata  <= SYNC;
                  o_tlast  <= 1'b0;
               end
            end
            ST_SEND: begin
               if (i_tready) begin
                  if (r_idx == IDX_LAST) begin
                     r_idx   <= 4'd0;
                     o_tlast <= 1'b0;
                     if (w_pop) begin
                        // Back-to-back frame: no idle bubble.
                        r_hold  <= w_head;
                        o_tdata <= SYNC;
                     end else begin
                        r_state  <= ST_IDLE;
                        o_tvalid <= 1'b0;
                        o_tdata  <= 8'h00;
                     end
                  end else begin
                     r_idx   <= 4'(r_idx + 4'd1);
                     o_tdata <= frame_byte(r_hold, 4'(r_idx + 4'd1), SYNC);
                     o_tlast <= (4'(r_idx + 4'd1) == IDX_LAST);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Drop accounting, sticky lost flag and busy status.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lost     <= 1'b0;
         o_drop_cnt <= 8'h00;
         o_busy     <= 1'b0;
      end else begin
         if (w_drop) begin
            r_lost <= 1'b1;
            if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
         end else if (w_push) begin
            r_lost <= 1'b0;
         end
         o_busy <= w_send_nxt | (w_count_nxt != '0);
      end
   end

endmodule

// File: tb/tb_serv_trace_packer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_serv_trace_packer;

   localparam int unsigned DEPTH = 4;
   localparam logic [7:0]  SYNC  = 8'hA5;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        valid;
   logic [31:0] pc;
   logic [31:0] insn;
   logic [4:0]  rd;
   logic [31:0] wd;
   logic        trap;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic [7:0]  drop_cnt;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   serv_trace_packer #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_en            (en),
      .i_rvfi_valid    (valid),
      .i_rvfi_pc_rdata (pc),
      .i_rvfi_insn     (insn),
      .i_rvfi_rd_addr  (rd),
      .i_rvfi_rd_wdata (wd),
      .i_rvfi_trap     (trap),
      .o_tdata         (tdata),
      .o_tvalid        (tvalid),
      .i_tready        (tready),
      .o_tlast         (tlast),
      .o_drop_cnt      (drop_cnt),
      .o_busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        lost;
      logic        trap;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] wdata;
   } rec_t;

   function automatic logic [7:0] rec_byte(input rec_t r, input int k);
      logic [31:0] w;
      if (k == 0) return SYNC;
      if (k == 1) return {r.lost, r.trap, 1'b0, r.rd};
      if (k < 6)       w = r.pc    >> (8 * (k - 2));
      else if (k < 10) w = r.insn  >> (8 * (k - 6));
      else             w = r.wdata >> (8 * (k - 10));
      return w[7:0];
   endfunction

   rec_t m_q[$];
   rec_t m_cur;
   bit   m_in;
   int   m_pos;
   bit   m_lost;
   int   m_drop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_in   = 0;
         m_pos  = 0;
         m_lost = 0;
         m_drop = 0;
      end else begin
         bit   was_full;
         bit   take;
         rec_t r;
         was_full = (m_q.size() == DEPTH);
         take = 0;
         if (!m_in) begin
            take = (m_q.size() > 0);
         end else if (tready) begin
            if (m_pos == 13) begin
               if (m_q.size() > 0) take = 1;
               else m_in = 0;
            end else begin
               m_pos++;
            end
         end
         if (take) begin
            m_cur = m_q.pop_front();
            m_in  = 1;
            m_pos = 0;
         end
         if (en && valid) begin
            if (!was_full) begin
               r.lost  = m_lost;
               r.trap  = trap;
               r.rd    = rd;
               r.pc    = pc;
               r.insn  = insn;
               r.wdata = (rd == 5'd0) ? 32'd0 : wd;
               m_q.push_back(r);
               m_lost = 0;
            end else begin
               if (m_drop < 255) m_drop++;
               m_lost = 1;
            end
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("tvalid", 32'(tvalid), 32'(m_in));
         check("tdata", 32'(tdata), m_in ? 32'(rec_byte(m_cur, m_pos)) : 32'd0);
         check("tlast", 32'(tlast), 32'(m_in && m_pos == 13));
         check("busy", 32'(busy), 32'(m_in || m_q.size() > 0));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      end
   end

   // Collect accepted bytes as {tlast, tdata}.
   logic [8:0] cap[$];
   always @(posedge clk) begin
      if (rst_n && tvalid && tready) cap.push_back({tlast, tdata});
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_rand_fields();
      pc   = $urandom;
      insn = $urandom;
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wd   = $urandom;
      trap = 1'($urandom_range(0, 7) == 0);
   endtask

   task automatic retire(input logic [31:0] p, input logic [31:0] i, input logic [4:0] r,
                         input logic [31:0] w, input logic t);
      pc = p; insn = i; rd = r; wd = w; trap = t;
      en = 1'b1; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_cap(input int n, input int budget, input string name);
      int c;
      c = 0;
      while (cap.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(name, 32'(cap.size() >= n), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] exp1 [14];
   int         n_hi;
   int         n_rise;
   int         n_busy;
   logic       prev;

   initial begin
      exp1 = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h93,
               8'h00, 8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      rst_n = 1'b0; en = 1'b0; valid = 1'b0; tready = 1'b1;
      pc = '0; insn = '0; rd = '0; wd = '0; trap = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tdata", 32'(tdata), 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single record: exact stream and latency
      cap.delete();
      retire(32'h0000_0100, 32'h0050_0093, 5'd1, 32'd5, 1'b0);
      check("lat_edgeN_tvalid", 32'(tvalid), 32'd0);
      check("lat_edgeN_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("lat_edgeN1_tvalid", 32'(tvalid), 32'd1);
      check("lat_edgeN1_sync", 32'(tdata), 32'hA5);
      wait_cap(14, 40, "single_timeout");
      for (int k = 0; k < 14; k++) begin
         if (k < cap.size()) begin
            check($sformatf("single_byte%0d", k), 32'(cap[k][7:0]), 32'(exp1[k]));
            check($sformatf("single_last%0d", k), 32'(cap[k][8]), 32'(k == 13));
         end
      end
      check("single_busy_fall", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);

      // rd=0 zeroing with trap
      cap.delete();
      retire(32'h0000_0200, 32'h0000_0013, 5'd0, 32'hDEAD_BEEF, 1'b1);
      wait_cap(14, 40, "rd0_timeout");
      if (cap.size() >= 14) begin
         check("rd0_byte1", 32'(cap[1][7:0]), 32'h40);
         for (int k = 10; k < 14; k++)
            check($sformatf("rd0_wbyte%0d", k), 32'(cap[k][7:0]), 32'd0);
      end
      repeat (2) @(negedge clk);

      // Back-pressure during byte 3
      cap.delete();
      retire(32'h1122_3344, 32'hCAFE_0001, 5'd3, 32'h0000_0777, 1'b0);
      wait_cap(3, 40, "bp_reach3");
      tready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_tvalid", 32'(tvalid), 32'd1);
         check("bp_hold_tdata", 32'(tdata), 32'h33);
      end
      tready = 1'b1;
      wait_cap(14, 40, "bp_timeout");
      repeat (4) @(negedge clk);
      check("bp_count", 32'(cap.size()), 32'd14);
      if (cap.size() >= 14) check("bp_byte3", 32'(cap[3][7:0]), 32'h33);

      // Overflow: 7 valids with no ready
      do_reset();
      cap.delete();
      tready = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_rand_fields();
         valid = 1'b1;
         @(negedge clk);
      end
      valid = 1'b0;
      check("ovf_drop2", 32'(drop_cnt), 32'd2);
      tready = 1'b1;
      wait_cap(14, 40, "ovf_first_frame");
      set_rand_fields();
      retire(pc, insn, rd, wd, trap);
      wait_cap(84, 200, "ovf_timeout");
      repeat (4) @(negedge clk);
      check("ovf_frames", 32'(cap.size()), 32'd84);
      for (int f = 0; f < 6; f++) begin
         if (cap.size() >= 84)
            check($sformatf("ovf_lost_f%0d", f), 32'(cap[14*f+1][7]), 32'(f == 5));
      end
      check("ovf_drop_keep", 32'(drop_cnt), 32'd2);

      // Back-to-back: 3 records, 42 contiguous valid bytes
      do_reset();
      tready = 1'b1;
      en = 1'b1;
      n_hi = 0; n_rise = 0; prev = 1'b0;
      set_rand_fields();
      valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i < 2) set_rand_fields();
         if (i == 2) valid = 1'b0;
         if (tvalid) n_hi++;
         if (tvalid && !prev) n_rise++;
         prev = tvalid;
      end
      check("b2b_bytes", 32'(n_hi), 32'd42);
      check("b2b_contig", 32'(n_rise), 32'd1);

      // Saturation: 300 valids with no ready
      do_reset();
      tready = 1'b0;
      en = 1'b1;
      valid = 1'b1;
      repeat (300) begin
         set_rand_fields();
         @(negedge clk);
      end
      valid = 1'b0;
      check("sat_255", 32'(drop_cnt), 32'd255);

      // Reset mid-frame with 2 records queued
      do_reset();
      tready = 1'b1;
      cap.delete();
      en = 1'b1;
      valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_rand_fields();
         @(negedge clk);
      end
      valid = 1'b0;
      wait_cap(7, 40, "mid_reach7");
      rst_n = 1'b0;
      #1;
      check("mid_tvalid", 32'(tvalid), 32'd0);
      check("mid_tdata", 32'(tdata), 32'd0);
      check("mid_tlast", 32'(tlast), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n_hi = 0; n_busy = 0;
      repeat (20) begin
         @(negedge clk);
         if (tvalid) n_hi++;
         if (busy) n_busy++;
      end
      check("mid_quiet_tvalid", 32'(n_hi), 32'd0);
      check("mid_quiet_busy", 32'(n_busy), 32'd0);
      cap.delete();
      retire(32'h0000_0400, 32'h0000_0033, 5'd7, 32'h1234_5678, 1'b0);
      wait_cap(14, 40, "mid_new_frame");
      if (cap.size() >= 14) begin
         check("mid_new_sync", 32'(cap[0][7:0]), 32'hA5);
         check("mid_new_b1", 32'(cap[1][7:0]), 32'h07);
         check("mid_new_w0", 32'(cap[10][7:0]), 32'h78);
      end

      // Randomized phase checked against the model every cycle
      do_reset();
      for (int blk = 0; blk < 8; blk++) begin
         int rdy_pct;
         int vld_pct;
         rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 70 : 100);
         vld_pct = (blk % 2 == 0) ? 50 : 15;
         for (int i = 0; i < 500; i++) begin
            set_rand_fields();
            en     = ($urandom_range(0, 9) != 0);
            valid  = ($urandom_range(0, 99) < vld_pct);
            tready = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
         end
      end
      valid = 1'b0;
      tready = 1'b1;
      begin
         int c;
         c = 0;
         while (busy && c < 200) begin
            @(negedge clk);
            c++;
         end
         check("rand_drain", 32'(busy), 32'd0);
      end
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serv_trace_packer.md
# serv_trace_packer

Retired-instruction trace packer for SERV simulation and FPGA bring-up. Sits directly downstream of the RVFI introspection outputs. On each retirement it captures a compact record (PC, instruction word, destination register and written value, trap flag) into a small FIFO. A serializer drains the FIFO as a framed byte stream with a valid/ready handshake, so a UART or trace port can log execution without stalling the core. When the FIFO is full, records are dropped, counted and flagged rather than back-pressuring the CPU.

## Interface
- `DEPTH`, default 4: FIFO depth in records; must be a power of 2, ≥2.
- `SYNC`, default 8'hA5: frame sync byte.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_en` in 1: capture enable. When low, retirements are ignored and not counted as drops.
- `i_rvfi_valid` in 1: single-cycle retirement strobe.
- `i_rvfi_pc_rdata` in 32: PC of the retired instruction.
- `i_rvfi_insn` in 32: retired instruction word.
- `i_rvfi_rd_addr` in 5: destination register; 0 means no write.
- `i_rvfi_rd_wdata` in 32: value written to rd.
- `i_rvfi_trap` in 1: instruction trapped.
- `o_tdata` out 8: stream byte.
- `o_tvalid` out 1: stream byte valid.
- `i_tready` in 1: sink accepts the byte.
- `o_tlast` out 1: high on the final byte of a frame.
- `o_drop_cnt` out 8: dropped records, saturating.
- `o_busy` out 1: FIFO non-empty or a frame is in progress.

## Operation
- **Push:** a record is pushed on a clock edge where `i_en & i_rvfi_valid & !full`. All inputs are sampled on that edge.
- **Full:** `full` is evaluated from the occupancy at the start of the cycle. A pop in the same cycle does not make room for a push.
- **Drop:** `i_en & i_rvfi_valid & full` drops the record.
  - `o_drop_cnt` increments, saturating at 255.
  - A sticky `lost` flag is set.
  - The next successfully pushed record stores `lost=1`, and `lost` clears on that push.
- **Record:** 103 bits: {lost, trap, rd_addr[4:0], pc[31:0], insn[31:0], wdata[31:0]}. wdata is stored as 0 when rd_addr==0.
- **Frame:** 14 bytes, multi-byte fields little-endian.
  - Byte 0: `SYNC`.
  - Byte 1: {lost, trap, 1'b0, rd_addr}.
  - Bytes 2–5: pc.
  - Bytes 6–9: insn.
  - Bytes 10–13: wdata.
- **Serializer FSM:** states IDLE and SEND, with a 4-bit byte index 0..13.
  - IDLE → SEND when the FIFO is non-empty. The head record is latched into a shift/hold register and the FIFO is popped on the same edge. The index resets to 0.
  - SEND: `o_tvalid`=1. The index advances on each `o_tvalid & i_tready` edge.
  - At index 13 with handshake: if the FIFO is non-empty, load the next record and stay in SEND with index 0, giving back-to-back frames with no bubble. Otherwise go to IDLE.
- **Handshake rules:**
  - `o_tdata`/`o_tlast` are stable while `o_tvalid & !i_tready`.
  - `o_tvalid` never deasserts mid-frame.
  - `o_tlast` = SEND & index==13.
- **`o_busy`** = SEND | FIFO non-empty.

## Timing
- **Reset** (async assert, sync release):
  - FIFO empty, FSM IDLE, index 0, `lost`=0.
  - `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `o_drop_cnt`=0, `o_busy`=0.
  - Reset mid-frame aborts the frame and discards the buffered records.
- **Latency:**
  - A retirement pushed at edge N causes the FIFO-not-empty transition, so IDLE→SEND happens at edge N+1.
  - Byte 0 is therefore valid in cycle N+1→N+2, two edges after the strobe edge.
- **Throughput:** one frame per 14 `i_tready` cycles. Holding state and FIFO together store up to DEPTH+1 records.
- **Simultaneous push on the pop edge:** allowed when not full. FIFO pointers wrap modulo DEPTH, with an extra occupancy bit to distinguish full from empty.

## Structure
- Package `serv_trace_pkg`:
  - `SYNC_DEFAULT`.
  - `FRAME_BYTES`=14.
  - Record field bit offsets and `REC_W`=103.
  - FSM state encoding (IDLE=1'b0, SEND=1'b1).
- Sub-module `serv_trace_fifo`: parameterized width/depth synchronous FIFO. Ports: push, pop, din, dout, full, empty, async active-low reset. The packer instantiates it with `REC_W`.

## Test plan
- **Single record.** Reset, `i_tready`=1. Pulse valid with pc=0x00000100, insn=0x00500093, rd=1, wdata=5, trap=0. Required stream: A5 01 00 01 00 00 93 00 50 00 05 00 00 00, with `o_tlast` on byte 14 only; `o_busy` falls after it.
- **rd=0 zeroing.** Pulse valid with rd=0, wdata=0xDEADBEEF, trap=1. Byte 1 = 0x40; bytes 10–13 = 00.
- **Back-pressure.** Hold `i_tready`=0 for 5 cycles during byte 3. `o_tdata`/`o_tvalid` stay constant; the frame completes intact and the byte count is exactly 14.
- **Overflow.** DEPTH=4, `i_tready`=0, 7 consecutive valids.
  - 5 are stored (1 held + 4 in the FIFO); `o_drop_cnt`=2.
  - Release ready, then send 1 more valid: 6 frames appear, and only the 6th frame has byte1[7]=1.
- **Back-to-back and saturation.**
  - 3 valids with `i_tready`=1: 42 contiguous valid bytes with no gap.
  - Separately, 300 drops: `o_drop_cnt` holds 255.
- **Reset mid-frame.** Assert `i_rst_n`=0 at byte 7 with 2 records queued. Outputs go to zero immediately. After release there is no output until a new valid arrives.
